risc16f84_aux_arbiter: RTL

Two-master arbiter for the risc16f84 auxiliary bus. It shares one auxiliary slave (aux RAM or peripheral block, 16-bit address, 8-bit data) between the PIC core's aux port and a host/debug port. The CPU has default priority. The host gets the bus in idle CPU slots, or by force once a starvation limit is reached; a forced grant stalls the core through its clock enable. It sits between the core (via the core-side tristate split wrapper) and the aux slave.

---
 rtl/risc16f84_aux_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/risc16f84_aux_arbiter.sv
// Two-master arbiter sharing the risc16f84 auxiliary slave between the core and a host port.
// The core has default priority; the host wins idle slots or forces a one-cycle core stall once starved.
module risc16f84_aux_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clk_en_i,
  output logic                   cpu_clk_en_o,
  input  logic [15:0]            cpu_adr_i,
  input  logic [7:0]             cpu_dat_i,
  output logic [7:0]             cpu_dat_o,
  input  logic                   cpu_we_i,
  input  logic                   cpu_re_i,
  input  logic                   host_req_i,
  input  logic                   host_we_i,
  input  logic [15:0]            host_adr_i,
  input  logic [7:0]             host_dat_i,
  output logic [7:0]             host_dat_o,
  output logic                   host_ack_o,
  output logic [15:0]            mem_adr_o,
  output logic [7:0]             mem_dat_o,
  input  logic [7:0]             mem_dat_i,
  output logic                   mem_we_o,
  output logic                   mem_re_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // A limit of 0 still needs a one-bit counter that never leaves zero.
  localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_req;
  logic              host_pend;
  logic              starve;
  logic              grant_host;
  logic              grant_cpu;

  assign cpu_req    = clk_en_i & (cpu_we_i | cpu_re_i);
  assign host_pend  = host_req_i & ~host_ack_o;
  assign starve     = (wait_cnt == WAIT_MAX);
  assign grant_host = ~reset_i & host_pend & (~cpu_req | starve);
  assign grant_cpu  = ~reset_i & cpu_req & ~grant_host;

  assign cpu_clk_en_o = clk_en_i & ~(cpu_req & grant_host);
  assign cpu_dat_o    = mem_dat_i;

  always_comb begin
    mem_adr_o = cpu_adr_i;
    mem_dat_o = cpu_dat_i;
    mem_we_o  = 1'b0;
    mem_re_o  = 1'b0;
    if (grant_host) begin
      mem_adr_o = host_adr_i;
      mem_dat_o = host_dat_i;
      mem_we_o  = host_we_i;
      mem_re_o  = ~host_we_i;
    end else if (grant_cpu) begin
      mem_we_o  = cpu_we_i;
      mem_re_o  = cpu_re_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      host_ack_o  <= 1'b0;
      host_dat_o  <= 8'h00;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
    end else begin
      host_ack_o <= grant_host;
      if (grant_host && !host_we_i) begin
        host_dat_o <= mem_dat_i;
      end
      if (grant_host) begin
        wait_cnt <= '0;
      end else if (host_pend && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      // Counts only cycles where the core actually lost a conflict.
      if (cpu_req && grant_host && !(&stall_cnt_o)) begin
        stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
      end
    end
  end

endmodule
